// File: rtl/math_arbiter.sv
// Round-robin arbiter that time-shares one external combinational 4-bit add/sub
// unit between two clients; one operation in flight, result held until acknowledged.
module math_arbiter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req0_valid,
   input  logic         req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   output logic         req0_ready,
   output logic         rsp0_valid,
   output logic [W-1:0] rsp0_result,
   output logic         rsp0_ovf,
   input  logic         rsp0_ack,
   input  logic         req1_valid,
   input  logic         req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         req1_ready,
   output logic         rsp1_valid,
   output logic [W-1:0] rsp1_result,
   output logic         rsp1_ovf,
   input  logic         rsp1_ack,
   output logic [W-1:0] mb_a,
   output logic [W-1:0] mb_b,
   input  logic [W-1:0] mb_sum,
   input  logic [W-1:0] mb_diff
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]   state_q, state_d;
   logic         rr_q, rr_d;
   logic         owner_q, owner_d;
   logic         op_q, op_d;
   logic         ovf_q, ovf_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [W-1:0] result_q, result_d;

   logic any_valid;
   logic grant;
   logic ack_sel;

   // With both clients valid the rr pointer decides; otherwise the lone requester wins.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant = rr_q;
      end else begin
         grant = req1_valid;
      end
   end

   assign req0_ready = (state_q == ST_IDLE) && any_valid && !grant;
   assign req1_ready = (state_q == ST_IDLE) && any_valid && grant;

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      owner_d  = owner_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      ack_sel  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               owner_d = grant;
               op_d    = grant ? req1_op : req0_op;
               a_d     = grant ? req1_a  : req0_a;
               b_d     = grant ? req1_b  : req0_b;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = op_q ? mb_diff : mb_sum;
            // Signed overflow: operand signs (B inverted for subtract) agree but result sign differs.
            if (op_q) begin
               ovf_d = (a_q[W-1] != b_q[W-1]) && (mb_diff[W-1] != a_q[W-1]);
            end else begin
               ovf_d = (a_q[W-1] == b_q[W-1]) && (mb_sum[W-1] != a_q[W-1]);
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            ack_sel = owner_q ? rsp1_ack : rsp0_ack;
            if (ack_sel) begin
               rr_d    = ~owner_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         rr_q     <= 1'b0;
         owner_q  <= 1'b0;
         op_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         owner_q  <= owner_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   assign mb_a        = a_q;
   assign mb_b        = b_q;
   assign rsp0_valid  = (state_q == ST_RESP) && !owner_q;
   assign rsp1_valid  = (state_q == ST_RESP) && owner_q;
   assign rsp0_result = result_q;
   assign rsp1_result = result_q;
   assign rsp0_ovf    = ovf_q;
   assign rsp1_ovf    = ovf_q;

endmodule

// File: tb/tb_math_arbiter.sv
// Scoreboard bench for math_arbiter: drivers push expected results per client,
// a negedge monitor pops and compares whenever a response rises.
module tb_math_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req0_valid, req0_op, req0_ready, rsp0_valid, rsp0_ovf, rsp0_ack;
   logic       req1_valid, req1_op, req1_ready, rsp1_valid, rsp1_ovf, rsp1_ack;
   logic [3:0] req0_a, req0_b, rsp0_result, req1_a, req1_b, rsp1_result;
   logic [3:0] mb_a, mb_b, mb_sum, mb_diff;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc0 = 0;
   int acc_cyc1 = 0;
   logic prev0 = 1'b0;
   logic prev1 = 1'b0;
   logic [4:0] exp0_q[$];
   logic [4:0] exp1_q[$];
   int grant_log[$];

   always #5 clk = ~clk;

   // Shared arithmetic unit (environment)
   assign mb_sum  = mb_a + mb_b;
   assign mb_diff = mb_a - mb_b;

   math_arbiter #(.W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
      .rsp0_ovf(rsp0_ovf), .rsp0_ack(rsp0_ack),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
      .rsp1_ovf(rsp1_ovf), .rsp1_ack(rsp1_ack),
      .mb_a(mb_a), .mb_b(mb_b), .mb_sum(mb_sum), .mb_diff(mb_diff)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: mutual exclusion, grant log, response scoreboard and latency
   initial forever begin
      logic [4:0] e;
      @(negedge clk);
      if (reset_n) begin
         if (req0_ready || req1_ready) begin
            chk("one_ready", {31'd0, req0_ready & req1_ready}, 0);
            if (req0_ready) begin grant_log.push_back(0); acc_cyc0 = cyc; end
            if (req1_ready) begin grant_log.push_back(1); acc_cyc1 = cyc; end
         end
         if (rsp0_valid || rsp1_valid)
            chk("one_rsp", {31'd0, rsp0_valid & rsp1_valid}, 0);
         if (rsp0_valid && !prev0) begin
            if (exp0_q.size() == 0) chk("rsp0_unexpected", 1, 0);
            else begin
               e = exp0_q.pop_front();
               chk("rsp0_result", {28'd0, rsp0_result}, {28'd0, e[3:0]});
               chk("rsp0_ovf", {31'd0, rsp0_ovf}, {31'd0, e[4]});
               chk("rsp0_latency", cyc - acc_cyc0, 2);
            end
         end
         if (rsp1_valid && !prev1) begin
            if (exp1_q.size() == 0) chk("rsp1_unexpected", 1, 0);
            else begin
               e = exp1_q.pop_front();
               chk("rsp1_result", {28'd0, rsp1_result}, {28'd0, e[3:0]});
               chk("rsp1_ovf", {31'd0, rsp1_ovf}, {31'd0, e[4]});
               chk("rsp1_latency", cyc - acc_cyc1, 2);
            end
         end
      end
      prev0 = rsp0_valid && reset_n;
      prev1 = rsp1_valid && reset_n;
   end

   task automatic do_req(input int c, input logic op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] er, input logic eo);
      logic got = 1'b0;
      if (c == 0) exp0_q.push_back({eo, er}); else exp1_q.push_back({eo, er});
      @(posedge clk); #1;
      if (c == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
      else        begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = (c == 0) ? req0_ready : req1_ready;
      end
      if (!got) chk(c == 0 ? "req0_timeout" : "req1_timeout", 0, 1);
      @(posedge clk); #1;
      if (c == 0) req0_valid = 0; else req1_valid = 0;
   endtask

   task automatic take_rsp(input int c, input int hold);
      logic got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = (c == 0) ? rsp0_valid : rsp1_valid;
      end
      if (!got) chk(c == 0 ? "rsp0_timeout" : "rsp1_timeout", 0, 1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("rsp_held", {31'd0, (c == 0) ? rsp0_valid : rsp1_valid}, 1);
      end
      @(posedge clk); #1;
      if (c == 0) rsp0_ack = 1; else rsp1_ack = 1;
      @(posedge clk); #1;
      if (c == 0) rsp0_ack = 0; else rsp1_ack = 0;
   endtask

   task automatic wait_rsp0();
      logic got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = rsp0_valid;
      end
      if (!got) chk("rsp0_wait_timeout", 0, 1);
   endtask

   task automatic do_reset();
      reset_n = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
   endtask

   task automatic chk_grants(input string name, input int n);
      chk(name, grant_log.size(), n);
      for (int i = 0; i < n && i < grant_log.size(); i++)
         chk(name, grant_log[i], i % 2);
   endtask

   // Directed vectors: client, op, A, B, expected result, expected ovf
   int         v_c  [6] = '{1, 1, 1, 0, 0, 0};
   logic       v_op [6] = '{1, 0, 1, 0, 1, 0};
   logic [3:0] v_a  [6] = '{4'h2, 4'h7, 4'h8, 4'h8, 4'h0, 4'hF};
   logic [3:0] v_b  [6] = '{4'h5, 4'h1, 4'h1, 4'h8, 4'h8, 4'h1};
   logic [3:0] v_r  [6] = '{4'hD, 4'h8, 4'h7, 4'h0, 4'h8, 4'h0};
   logic       v_o  [6] = '{0, 1, 1, 1, 1, 0};

   initial begin
      {req0_valid, req0_op, req0_a, req0_b, rsp0_ack} = '0;
      {req1_valid, req1_op, req1_a, req1_b, rsp1_ack} = '0;
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
      chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 0);
      chk("rst_mb", {24'd0, mb_a, mb_b}, 0);
      chk("rst_result", {26'd0, rsp0_result, rsp0_ovf, rsp1_ovf}, 0);

      // 1: single add, ready for one cycle, response held until ack
      do_req(0, 0, 4'd3, 4'd4, 4'd7, 0);
      @(negedge clk);
      chk("t1_ready_one_cycle", {31'd0, req0_ready}, 0);
      take_rsp(0, 3);

      // 2: directed arithmetic vectors incl. overflow boundaries
      for (int i = 0; i < 6; i++) begin
         do_req(v_c[i], v_op[i], v_a[i], v_b[i], v_r[i], v_o[i]);
         take_rsp(v_c[i], 0);
      end

      // 3: both continuously valid from reset -> 0,1,0,1
      do_reset();
      grant_log.delete();
      fork
         begin
            do_req(0, 0, 4'd5, 4'd6, 4'hB, 1); take_rsp(0, 0);
            do_req(0, 1, 4'd6, 4'd3, 4'h3, 0); take_rsp(0, 0);
         end
         begin
            do_req(1, 0, 4'hE, 4'h1, 4'hF, 0); take_rsp(1, 0);
            do_req(1, 1, 4'h9, 4'h2, 4'h7, 1); take_rsp(1, 0);
         end
      join
      chk_grants("t3_grant_order", 4);

      // 4: withheld ack blocks client 1, then client 1 granted right after
      do_req(0, 0, 4'd6, 4'd1, 4'd7, 0);
      wait_rsp0();
      @(posedge clk); #1;
      exp1_q.push_back({1'b0, 4'd2});
      req1_valid = 1; req1_op = 1; req1_a = 4'd3; req1_b = 4'd1;
      repeat (5) begin
         @(negedge clk);
         chk("t4_req1_blocked", {31'd0, req1_ready}, 0);
         chk("t4_rsp0_stable", {27'd0, rsp0_valid, rsp0_result}, {27'd0, 1'b1, 4'd7});
      end
      @(posedge clk); #1 rsp0_ack = 1;
      @(posedge clk); #1 rsp0_ack = 0;
      @(negedge clk);
      chk("t4_grant1_next", {31'd0, req1_ready}, 1);
      @(posedge clk); #1 req1_valid = 0;
      take_rsp(1, 0);

      // 6: operands latched at accept; non-owner ack ignored (leaves rr=1)
      do_req(0, 0, 4'd3, 4'd2, 4'd5, 0);
      req0_a = 4'd9;
      @(negedge clk);
      chk("t6_mb_a_latched", {28'd0, mb_a}, 3);
      wait_rsp0();
      @(posedge clk); #1 rsp1_ack = 1;
      repeat (2) begin
         @(negedge clk);
         chk("t6_foreign_ack", {27'd0, rsp0_valid, rsp0_result}, {27'd0, 1'b1, 4'd5});
      end
      @(posedge clk); #1 rsp1_ack = 0;
      take_rsp(0, 0);

      // 5: reset during EXEC discards the op and returns rr to client 0
      do_req(0, 0, 4'd1, 4'd1, 4'd2, 0);
      reset_n = 0;
      @(posedge clk); #1 reset_n = 1;
      exp0_q.delete();
      @(negedge clk);
      chk("t5_outputs_zero", {22'd0, mb_a, mb_b, rsp0_result, rsp0_ovf, rsp1_ovf}, 0);
      repeat (3) begin
         chk("t5_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 0);
         @(negedge clk);
      end
      grant_log.delete();
      fork
         begin do_req(0, 1, 4'd4, 4'd4, 4'd0, 0); take_rsp(0, 0); end
         begin do_req(1, 0, 4'd2, 4'd3, 4'd5, 0); take_rsp(1, 0); end
      join
      chk_grants("t5_grant_order", 2);

      repeat (3) @(negedge clk);
      chk("exp_queues_empty", exp0_q.size() + exp1_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
